// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - multi-channel PWM generator with shared prescaler and period-boundary reload
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   EN         run enable; while low the counter idles and active copies track shadow/TOP/MODE
//   DIV        prescaler; one tick every DIV+1 clocks
//   TOP        period top value, sampled at each period boundary
//   MODE       0 = edge-aligned, 1 = center-aligned, sampled at each period boundary
//   WR_EN      duty write strobe
//   WR_ADDR    channel index for duty write (indices >= N_CH are ignored)
//   WR_DATA    duty value written to the shadow register
//   PWM        registered PWM outputs, one per channel
//   CYC_START  one-clock pulse in the clock following each period boundary
module pwm_multi_ctrl #(
  parameter int N_CH   = 10,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DIV_W-1:0]  DIV,
  input  logic [CNT_W-1:0]  TOP,
  input  logic              MODE,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [CNT_W-1:0]  WR_DATA,
  output logic [N_CH-1:0]   PWM,
  output logic              CYC_START
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [DIV_W-1:0] pre;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;
  logic [CNT_W-1:0] top_act;
  logic             mode_act;
  logic [CNT_W-1:0] shadow   [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];
  logic             tick;
  logic             boundary;
  logic             reload;

  assign tick = EN && (pre == DIV);

  // A boundary is the tick whose successor count is 0. In center mode with
  // top_act==1 the up-phase peak is also the last count of the period.
  always_comb begin
    boundary = 1'b0;
    if (top_act == '0)
      boundary = 1'b1;
    else if (!mode_act)
      boundary = (cnt == top_act);
    else if (dir == DIR_DOWN)
      boundary = (cnt == CNT_W'(1));
    else
      boundary = (cnt == top_act) && (top_act == CNT_W'(1));
  end

  // Next counter/direction; reload marks the edges where the active copies
  // are refreshed (every idle clock, and each boundary while running).
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    reload  = 1'b0;
    if (!EN) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
      reload  = 1'b1;
    end else if (tick) begin
      if (boundary) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        reload  = 1'b1;
      end else if (!mode_act) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else if (dir == DIR_UP) begin
        if (cnt == top_act) begin
          dir_nxt = DIR_DOWN;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre       <= '0;
      cnt       <= '0;
      dir       <= DIR_UP;
      top_act   <= '0;
      mode_act  <= 1'b0;
      PWM       <= '0;
      CYC_START <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i]   <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      pre       <= (!EN || tick) ? '0 : pre + DIV_W'(1);
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      CYC_START <= tick && boundary;
      if (reload) begin
        top_act  <= TOP;
        mode_act <= MODE;
      end
      for (int i = 0; i < N_CH; i++) begin
        // duty_act samples the shadow value from before any same-edge write.
        if (reload)
          duty_act[i] <= shadow[i];
        if (WR_EN && (WR_ADDR == ADDR_W'(i)))
          shadow[i] <= WR_DATA;
        PWM[i] <= EN && (cnt < duty_act[i]);
      end
    end
  end

endmodule

// File: doc/pwm_multi_ctrl.md
PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 10, number of PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, counter/duty/top width.
REQ-003 SHALL have parameter DIV_W, default 16, prescaler width.
REQ-004 SHALL have parameter ADDR_W, default 4, channel address width (2^ADDR_W >= N_CH).
REQ-005 SHALL have port CLK  in  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port EN  in  1  run enable.
REQ-008 SHALL have port DIV  in  DIV_W  prescale; one tick every DIV+1 clocks.
REQ-009 SHALL have port TOP  in  CNT_W  period top value.
REQ-010 SHALL have port MODE  in  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 SHALL have port WR_EN  in  1  duty write strobe.
REQ-012 SHALL have port WR_ADDR  in  ADDR_W  channel index for write.
REQ-013 SHALL have port WR_DATA  in  CNT_W  duty value.
REQ-014 SHALL have port PWM  out  N_CH  registered PWM outputs.
REQ-015 SHALL have port CYC_START  out  1  one-clock pulse at each period boundary.

Function
REQ-016 SHALL count prescaler pre 0..DIV while EN=1; tick = (pre==DIV), pre wraps to 0 on tick; DIV=0 gives tick every clock.
REQ-017 SHALL hold per-channel shadow duty registers; WR_EN=1 with WR_ADDR<N_CH writes WR_DATA to shadow[WR_ADDR] next edge; WR_ADDR>=N_CH ignored, no state change.
REQ-018 SHALL hold active copies duty_act[], top_act, mode_act; counter cnt, direction dir use only active copies.
REQ-019 Edge mode: on tick cnt increments 0..top_act, then wraps to 0; period = top_act+1 ticks.
REQ-020 Center mode: on tick cnt follows 0,1..top_act,top_act-1..1, then 0; dir flips to down at cnt==top_act; period = 2*top_act ticks.
REQ-021 Boundary = tick whose next cnt is 0: edge cnt==top_act; center down-phase cnt==1, or up-phase cnt==top_act==1; either mode top_act==0 (cnt stays 0, every tick is boundary).
REQ-022 At boundary SHALL set cnt<=0, dir<=up, duty_act[i]<=shadow[i], top_act<=TOP, mode_act<=MODE, all on same edge.
REQ-023 Write coinciding with boundary: shadow takes WR_DATA, duty_act takes pre-write shadow; new value active at next boundary.
REQ-024 CYC_START SHALL be 1 for exactly the clock following a boundary edge, else 0.
REQ-025 PWM[i] SHALL be registered as (cnt < duty_act[i]) using current cnt, i.e. one clock latency after cnt update; unsigned compare at CNT_W bits.
REQ-026 duty_act[i]=0 -> PWM[i] constant 0; duty_act[i] > top_act -> constant 1 (edge) / constant 1 (center).
REQ-027 EN=0: pre, cnt held 0, dir up, PWM all 0, CYC_START 0; shadow writes still accepted; active copies reload from shadow/TOP/MODE every clock.
REQ-028 EN 0->1: first tick after DIV+1 clocks; first period uses values loaded during EN=0.
REQ-029 TOP/MODE changes mid-period SHALL have no effect until next boundary.

Reset
REQ-030 RST=1 SHALL asynchronously clear pre, cnt, dir(up), shadow[], duty_act[], top_act, mode_act, PWM, CYC_START to 0.
REQ-031 After RST deassert, behaviour starts per REQ-027/028; reset mid-period aborts period, no partial pulse survives.

Verification
REQ-032 N_CH=4, DIV=0, TOP=9, MODE=0, duty ch0=3, EN=1 -> PWM[0] high 3 clk, low 7 clk, period 10; CYC_START every 10 clk.
REQ-033 MODE=1, TOP=4, duty=2, DIV=1 -> cnt 0,1,2,3,4,3,2,1 each held 2 clk; PWM high while cnt<2 (6 of 16 clk); period 16 clk.
REQ-034 Write duty 5 to ch1 mid-period (TOP=9, old duty 2) -> current period keeps width 2; next period width 5, starting right after CYC_START.
REQ-035 duty=0 -> PWM low always; duty=10 with TOP=9 -> high always; WR_ADDR=7 with N_CH=4 -> no channel changes.
REQ-036 Assert RST mid-period with PWM high -> PWM, CYC_START 0 same cycle (async); after release with EN=1 all PWM 0 until new writes.
REQ-037 TOP=0 edge mode, duty=1 -> PWM constant 1, CYC_START every tick; change TOP to 3 mid-run -> new period starts only after boundary.
